// File: rtl/av_slave_port_arbiter_pkg.sv
// Shared Avalon crossbar definitions: bus field widths and arbiter state encoding.
// Used by the crossbar and by every slave port.
package av_bus_defs;

   localparam int AV_ADDR_W  = 30;
   localparam int AV_DATA_W  = 32;
   localparam int AV_BE_W    = 4;
   localparam int AV_BURST_W = 8;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } arb_state_t;

   // Index width that stays legal for a single-entry vector.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/av_slave_port_arbiter_picker.sv
// Round-robin picker: first request at or after ptr, searching upward modulo N.
module rr_priority_picker
   import av_bus_defs::*;
#(
   parameter int N = 5
) (
   input  logic [N-1:0]        req,
   input  logic [idx_w(N)-1:0] ptr,
   output logic [N-1:0]        gnt_oh,
   output logic [idx_w(N)-1:0] idx,
   output logic                any
);

   localparam int IW = idx_w(N);

   logic [IW-1:0] cand;

   always_comb begin
      gnt_oh = '0;
      idx    = '0;
      any    = 1'b0;
      cand   = '0;
      for (int i = 0; i < N; i++) begin
         cand = IW'((int'(ptr) + i) % N);
         if (!any && req[cand]) begin
            any          = 1'b1;
            idx          = cand;
            gnt_oh[cand] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/av_slave_port_arbiter.sv
// Round-robin arbiter in front of one crossbar slave port; holds the grant for a
// whole burst and forwards the granted master's transfer combinationally.
module av_slave_port_arbiter
   import av_bus_defs::*;
#(
   parameter int                       NUM_MASTERS   = 5,
   parameter int                       ADDR_SEL_BITS = 2,
   parameter logic [ADDR_SEL_BITS-1:0] ADDR_SEL      = 2'd3
) (
   input  logic                                i_Clk,
   input  logic                                i_nReset,
   input  logic [AV_ADDR_W*NUM_MASTERS-1:0]    i_AVIn_Addr,
   input  logic [AV_BE_W*NUM_MASTERS-1:0]      i_AVIn_ByteEn,
   input  logic [NUM_MASTERS-1:0]              i_AVIn_Read,
   input  logic [NUM_MASTERS-1:0]              i_AVIn_Write,
   input  logic [AV_DATA_W*NUM_MASTERS-1:0]    i_AVIn_WriteData,
   input  logic [AV_BURST_W*NUM_MASTERS-1:0]   i_AVIn_BurstCount,
   output logic [AV_DATA_W*NUM_MASTERS-1:0]    o_AVIn_ReadData,
   output logic [NUM_MASTERS-1:0]              o_AVIn_WaitRequest,
   output logic [AV_ADDR_W-1:0]                o_AVOut_Addr,
   output logic [AV_BE_W-1:0]                  o_AVOut_ByteEn,
   output logic                                o_AVOut_Read,
   output logic                                o_AVOut_Write,
   output logic [AV_DATA_W-1:0]                o_AVOut_WriteData,
   output logic [AV_BURST_W-1:0]               o_AVOut_BurstCount,
   input  logic [AV_DATA_W-1:0]                i_AVOut_ReadData,
   input  logic                                i_AVOut_WaitRequest
);

   localparam int IW = idx_w(NUM_MASTERS);

   arb_state_t            state, state_nxt;
   logic [IW-1:0]         gnt, gnt_nxt, rr_ptr, rr_ptr_nxt, win_idx;
   logic [AV_BURST_W-1:0] beats, beats_nxt, win_bc;
   logic [NUM_MASTERS-1:0] hit, win_oh;
   logic                  win_any, busy, beat_done;

   logic [AV_ADDR_W-1:0]  m_addr [NUM_MASTERS];
   logic [AV_BE_W-1:0]    m_be   [NUM_MASTERS];
   logic [AV_DATA_W-1:0]  m_wd   [NUM_MASTERS];
   logic [AV_BURST_W-1:0] m_bc   [NUM_MASTERS];

   assign busy = (state == ST_BUSY);

   // Non-granted masters stall on their own hit so the crossbar can OR ports together.
   for (genvar k = 0; k < NUM_MASTERS; k++) begin : g_m
      logic own;
      assign m_addr[k] = i_AVIn_Addr[AV_ADDR_W*k +: AV_ADDR_W];
      assign m_be[k]   = i_AVIn_ByteEn[AV_BE_W*k +: AV_BE_W];
      assign m_wd[k]   = i_AVIn_WriteData[AV_DATA_W*k +: AV_DATA_W];
      assign m_bc[k]   = i_AVIn_BurstCount[AV_BURST_W*k +: AV_BURST_W];
      assign hit[k]    = (i_AVIn_Read[k] | i_AVIn_Write[k]) &
                         (m_addr[k][AV_ADDR_W-1 -: ADDR_SEL_BITS] == ADDR_SEL);
      assign own       = busy && (gnt == IW'(k));
      assign o_AVIn_WaitRequest[k] = own ? i_AVOut_WaitRequest : hit[k];
      assign o_AVIn_ReadData[AV_DATA_W*k +: AV_DATA_W] = own ? i_AVOut_ReadData : '0;
   end

   rr_priority_picker #(.N(NUM_MASTERS)) u_pick (
      .req    (hit),
      .ptr    (rr_ptr),
      .gnt_oh (win_oh),
      .idx    (win_idx),
      .any    (win_any)
   );

   always_comb begin
      win_bc = '0;
      for (int k = 0; k < NUM_MASTERS; k++)
         win_bc = win_bc | (win_oh[k] ? m_bc[k] : '0);
   end

   always_comb begin
      o_AVOut_Addr       = '0;
      o_AVOut_ByteEn     = '0;
      o_AVOut_WriteData  = '0;
      o_AVOut_BurstCount = '0;
      o_AVOut_Read       = 1'b0;
      o_AVOut_Write      = 1'b0;
      if (busy) begin
         o_AVOut_Addr       = m_addr[gnt];
         o_AVOut_ByteEn     = m_be[gnt];
         o_AVOut_WriteData  = m_wd[gnt];
         o_AVOut_BurstCount = m_bc[gnt];
         o_AVOut_Read       = i_AVIn_Read[gnt] & hit[gnt];
         o_AVOut_Write      = i_AVIn_Write[gnt] & hit[gnt];
      end
   end

   assign beat_done = (o_AVOut_Read | o_AVOut_Write) & ~i_AVOut_WaitRequest;

   always_comb begin
      state_nxt  = state;
      gnt_nxt    = gnt;
      beats_nxt  = beats;
      rr_ptr_nxt = rr_ptr;
      case (state)
         ST_IDLE: begin
            if (win_any) begin
               state_nxt  = ST_BUSY;
               gnt_nxt    = win_idx;
               beats_nxt  = (win_bc == '0) ? AV_BURST_W'(1) : win_bc;
               rr_ptr_nxt = (win_idx == IW'(NUM_MASTERS-1)) ? '0 : win_idx + 1'b1;
            end
         end
         ST_BUSY: begin
            // Master withdrew mid-burst: drop the remaining beats.
            if (!hit[gnt]) begin
               state_nxt = ST_IDLE;
               beats_nxt = '0;
            end else if (beat_done) begin
               beats_nxt = beats - 1'b1;
               if (beats <= AV_BURST_W'(1))
                  state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_Clk or negedge i_nReset) begin
      if (!i_nReset) begin
         state  <= ST_IDLE;
         gnt    <= '0;
         beats  <= '0;
         rr_ptr <= '0;
      end else begin
         state  <= state_nxt;
         gnt    <= gnt_nxt;
         beats  <= beats_nxt;
         rr_ptr <= rr_ptr_nxt;
      end
   end

endmodule

// File: tb/tb_av_slave_port_arbiter.sv
// Directed scenarios plus randomized traffic checked against a behavioural arbiter model.
module tb_av_slave_port_arbiter;

   localparam int N = 5;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   logic [29:0] m_addr [N];
   logic [3:0]  m_be   [N];
   logic        m_rd   [N];
   logic        m_wr   [N];
   logic [31:0] m_wd   [N];
   logic [7:0]  m_bc   [N];

   logic [30*N-1:0] addr_bus;
   logic [4*N-1:0]  be_bus;
   logic [N-1:0]    rd_bus, wr_bus;
   logic [32*N-1:0] wd_bus;
   logic [8*N-1:0]  bc_bus;

   logic [32*N-1:0] in_rdata;
   logic [N-1:0]    in_wait;
   logic [29:0]     out_addr;
   logic [3:0]      out_be;
   logic            out_rd, out_wr;
   logic [31:0]     out_wd;
   logic [7:0]      out_bc;
   logic [31:0]     s_rdata = '0;
   logic            s_wait  = 1'b0;

   for (genvar k = 0; k < N; k++) begin : g_pack
      assign addr_bus[30*k +: 30] = m_addr[k];
      assign be_bus[4*k +: 4]     = m_be[k];
      assign wd_bus[32*k +: 32]   = m_wd[k];
      assign bc_bus[8*k +: 8]     = m_bc[k];
      assign rd_bus[k]            = m_rd[k];
      assign wr_bus[k]            = m_wr[k];
   end

   av_slave_port_arbiter dut (
      .i_Clk              (clk),
      .i_nReset           (rst_n),
      .i_AVIn_Addr        (addr_bus),
      .i_AVIn_ByteEn      (be_bus),
      .i_AVIn_Read        (rd_bus),
      .i_AVIn_Write       (wr_bus),
      .i_AVIn_WriteData   (wd_bus),
      .i_AVIn_BurstCount  (bc_bus),
      .o_AVIn_ReadData    (in_rdata),
      .o_AVIn_WaitRequest (in_wait),
      .o_AVOut_Addr       (out_addr),
      .o_AVOut_ByteEn     (out_be),
      .o_AVOut_Read       (out_rd),
      .o_AVOut_Write      (out_wr),
      .o_AVOut_WriteData  (out_wd),
      .o_AVOut_BurstCount (out_bc),
      .i_AVOut_ReadData   (s_rdata),
      .i_AVOut_WaitRequest(s_wait)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;

   // model: who owns the slave, beats left, next search start
   bit md_busy = 1'b0;
   int md_gnt = 0;
   int md_rem = 0;
   int md_ptr = 0;

   // last sampled observations, for scenario-level checks
   logic            obs_rd;
   logic [29:0]     obs_addr;
   logic [N-1:0]    obs_wait;
   logic [32*N-1:0] obs_rdata;
   int              obs_gnt;

   task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic bit is_hit(input int k);
      return (m_rd[k] || m_wr[k]) && (m_addr[k][29:28] == 2'd3);
   endfunction

   task automatic idle_all();
      for (int k = 0; k < N; k++) begin
         m_rd[k] = 1'b0; m_wr[k] = 1'b0;
      end
   endtask

   // One cycle: check all outputs against the model mid-cycle, advance model, cross the edge.
   task automatic step();
      logic [75:0]     exp_req;
      logic [N-1:0]    exp_wait;
      logic [32*N-1:0] exp_rdata;
      int w;
      #3;
      exp_req = '0;
      exp_rdata = '0;
      for (int k = 0; k < N; k++) exp_wait[k] = is_hit(k);
      if (md_busy) begin
         exp_wait[md_gnt] = s_wait;
         exp_rdata[32*md_gnt +: 32] = s_rdata;
         exp_req = {m_rd[md_gnt] & is_hit(md_gnt), m_wr[md_gnt] & is_hit(md_gnt),
                    m_addr[md_gnt], m_be[md_gnt], m_wd[md_gnt], m_bc[md_gnt]};
      end
      chk("slave_req", 160'({out_rd, out_wr, out_addr, out_be, out_wd, out_bc}), 160'(exp_req));
      chk("wait", 160'(in_wait), 160'(exp_wait));
      chk("rdata", 160'(in_rdata), 160'(exp_rdata));

      obs_rd = out_rd; obs_addr = out_addr; obs_wait = in_wait; obs_rdata = in_rdata;
      obs_gnt = -1;
      if (out_rd || out_wr)
         for (int k = N-1; k >= 0; k--)
            if (out_addr == m_addr[k]) obs_gnt = k;

      if (!md_busy) begin
         w = -1;
         for (int i = 0; i < N; i++)
            if (w < 0 && is_hit((md_ptr + i) % N)) w = (md_ptr + i) % N;
         if (w >= 0) begin
            md_busy = 1'b1;
            md_gnt  = w;
            md_rem  = (m_bc[w] == 8'd0) ? 1 : int'(m_bc[w]);
            md_ptr  = (w + 1) % N;
         end
      end else if (!is_hit(md_gnt)) begin
         md_busy = 1'b0;
      end else if (!s_wait) begin
         md_rem--;
         if (md_rem == 0) md_busy = 1'b0;
      end
      @(posedge clk);
      #1;
   endtask

   int exp_seq [12] = '{-1, 0, -1, 2, -1, 4, -1, 0, -1, 2, -1, 4};
   int wcyc, wbeats;

   initial begin
      for (int k = 0; k < N; k++) begin
         m_addr[k] = '0; m_be[k] = 4'hF; m_wd[k] = 32'h1000_0000 + 32'(k);
         m_bc[k] = 8'd1;
      end
      idle_all();

      // reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_req", 160'({out_rd, out_wr, out_addr, out_be, out_wd, out_bc}), 160'(0));
      chk("rst_wait", 160'(in_wait), 160'(0));
      chk("rst_rdata", 160'(in_rdata), 160'(0));
      rst_n = 1'b1;

      // round-robin fairness, single beats
      for (int k = 0; k < N; k += 2) begin
         m_addr[k] = 30'h3000_0000 + 30'(16*k); m_rd[k] = 1'b1;
      end
      for (int i = 0; i < 12; i++) begin
         step();
         chk("rr_seq", 160'(obs_gnt), 160'(exp_seq[i]));
      end
      idle_all();
      step();

      // single read
      s_rdata = 32'hDEADBEEF;
      m_addr[1] = 30'h3000_0010; m_rd[1] = 1'b1;
      step();
      chk("sr_wait0", 160'(obs_wait[1]), 160'(1'b1));
      step();
      chk("sr_read", 160'(obs_rd), 160'(1'b1));
      chk("sr_addr", 160'(obs_addr), 160'(30'h3000_0010));
      chk("sr_wait1", 160'(obs_wait[1]), 160'(1'b0));
      chk("sr_rdata", 160'(obs_rdata), 160'({32'hDEADBEEF, 32'h0}));
      idle_all();
      step();

      // burst hold with a stalled second beat
      wcyc = 0; wbeats = 0;
      m_addr[2] = 30'h3000_0200; m_wr[2] = 1'b1; m_bc[2] = 8'd4;
      for (int c = 0; c < 8; c++) begin
         if (c == 1) begin m_addr[0] = 30'h3000_0000; m_rd[0] = 1'b1; end
         s_wait = (c == 2);
         step();
         if (obs_gnt == 2) wcyc++;
         if (obs_gnt == 2 && !s_wait) wbeats++;
         if (c == 5) m_wr[2] = 1'b0;
         if (c == 6) chk("burst_bubble", 160'(obs_gnt), 160'(-1));
         if (c == 7) chk("burst_next", 160'(obs_gnt), 160'(0));
      end
      s_wait = 1'b0;
      chk("burst_cycles", 160'(wcyc), 160'(5));
      chk("burst_beats", 160'(wbeats), 160'(4));
      idle_all();
      step();

      // address miss
      m_addr[4] = 30'h0000_0040; m_rd[4] = 1'b1;
      for (int c = 0; c < 3; c++) begin
         step();
         chk("miss_wait", 160'(obs_wait[4]), 160'(1'b0));
         chk("miss_rd", 160'(obs_rd), 160'(1'b0));
      end
      idle_all();
      step();

      // abort after 3 of 8 beats
      m_addr[1] = 30'h3000_0100; m_rd[1] = 1'b1; m_bc[1] = 8'd8;
      step();
      m_addr[3] = 30'h3000_0300; m_rd[3] = 1'b1;
      for (int c = 0; c < 3; c++) begin
         step();
         chk("abort_beat", 160'(obs_gnt), 160'(1));
      end
      m_rd[1] = 1'b0;
      step();
      chk("abort_edge", 160'(obs_gnt), 160'(-1));
      step();
      chk("abort_idle", 160'(obs_gnt), 160'(-1));
      chk("abort_wait3", 160'(obs_wait[3]), 160'(1'b1));
      step();
      chk("abort_next", 160'(obs_gnt), 160'(3));
      idle_all();
      step();

      // reset mid-burst
      m_addr[3] = 30'h3000_0300; m_rd[3] = 1'b1; m_bc[3] = 8'd4;
      repeat (3) step();
      #2;
      chk("pre_rst_rd", 160'(out_rd), 160'(1'b1));
      rst_n = 1'b0;
      #1;
      chk("rst_mid_rd", 160'(out_rd), 160'(1'b0));
      chk("rst_mid_wait", 160'(in_wait), 160'(5'b01000));
      md_busy = 1'b0; md_ptr = 0;
      idle_all();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      m_addr[1] = 30'h3000_0110; m_rd[1] = 1'b1; m_bc[1] = 8'd1;
      m_addr[4] = 30'h3000_0140; m_rd[4] = 1'b1; m_bc[4] = 8'd1;
      step();
      step();
      chk("rst_ptr_gnt", 160'(obs_gnt), 160'(1));
      m_rd[1] = 1'b0;
      step();
      step();
      idle_all();
      step();

      // randomized traffic: sticky requests so bursts and aborts both occur
      for (int c = 0; c < 1500; c++) begin
         for (int k = 0; k < N; k++) begin
            if ($urandom_range(0, 5) == 0) begin
               m_rd[k]   = 1'($urandom);
               m_wr[k]   = ($urandom_range(0, 3) == 0);
               m_addr[k] = {($urandom_range(0, 3) != 0) ? 2'd3 : 2'($urandom), 28'($urandom)};
               m_be[k]   = 4'($urandom);
               m_wd[k]   = $urandom;
               m_bc[k]   = 8'($urandom_range(0, 3));
            end
         end
         s_wait  = ($urandom_range(0, 2) == 0);
         s_rdata = $urandom;
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
